// File: rtl/flash_loader.sv
// Boot-time SPI flash reader: issues one READ (0x03) command and streams NUM_BYTES
// bytes out on the load/addr/data write port feeding the VGA byte store.
module flash_loader #(
    parameter logic [23:0] FLASH_ADDR   = 24'h100000,
    parameter int unsigned NUM_BYTES    = 8,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned STARTUP_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              f_sclk,
    output logic              f_cs,
    output logic              f_mosi,
    input  logic              f_miso,
    output logic              load,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        data,
    output logic              f_done
);

    localparam int unsigned TOTAL_BITS = 32 + 8 * NUM_BYTES;
    localparam int unsigned BW = $clog2(TOTAL_BITS + 1);
    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned WW = (STARTUP_WAIT > 1) ? $clog2(STARTUP_WAIT) : 1;

    localparam logic [31:0]       CMD       = {8'h03, FLASH_ADDR};
    localparam logic [DW-1:0]     DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]     DIV_ONE   = DW'(1);
    localparam logic [WW-1:0]     WAIT_LAST = WW'(STARTUP_WAIT - 1);
    localparam logic [WW-1:0]     WAIT_ONE  = WW'(1);
    localparam logic [BW-1:0]     BIT_ONE   = BW'(1);
    localparam logic [BW-1:0]     CMD_BITS  = BW'(32);
    localparam logic [BW-1:0]     LAST_BIT  = BW'(TOTAL_BITS - 1);
    localparam logic [ADDR_W-1:0] BYTE_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_SETUP,
        ST_SHIFT,
        ST_TAIL,
        ST_CSHOLD,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WW-1:0]     wait_q, wait_d;
    logic [DW-1:0]     div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [31:0]       cmd_q, cmd_d;
    logic [6:0]        rx_q, rx_d;
    logic [ADDR_W-1:0] byte_q, byte_d;
    logic              sclk_q, sclk_d;
    logic              cs_q, cs_d;
    logic              mosi_q, mosi_d;
    logic              load_q, load_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              done_q, done_d;
    logic              rise;
    logic              div_tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_WAIT;
            wait_q  <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            cmd_q   <= '0;
            rx_q    <= '0;
            byte_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            cmd_q   <= cmd_d;
            rx_q    <= rx_d;
            byte_q  <= byte_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            load_q  <= load_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        div_d    = div_q;
        bit_d    = bit_q;
        cmd_d    = cmd_q;
        rx_d     = rx_q;
        byte_d   = byte_q;
        sclk_d   = sclk_q;
        cs_d     = cs_q;
        mosi_d   = mosi_q;
        load_d   = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        rise     = 1'b0;
        div_tick = (div_q == DIV_LAST);

        case (state_q)
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    cs_d    = 1'b0;
                    mosi_d  = CMD[31];
                    cmd_d   = {CMD[30:0], 1'b0};
                    div_d   = '0;
                    state_d = ST_SETUP;
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            ST_SETUP: begin
                if (div_tick) begin
                    div_d   = '0;
                    rise    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_SHIFT: begin
                if (div_tick) begin
                    div_d = '0;
                    if (sclk_q) begin
                        // Zeros shift in behind the command, so MOSI rests low after bit 0.
                        sclk_d = 1'b0;
                        mosi_d = cmd_q[31];
                        cmd_d  = {cmd_q[30:0], 1'b0};
                    end else begin
                        rise = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_TAIL: begin
                if (div_tick) begin
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    state_d = ST_CSHOLD;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            ST_CSHOLD: begin
                if (div_tick) begin
                    div_d   = '0;
                    cs_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: ;
        endcase

        // bit_q counts rising edges already taken; data bits begin at edge 32.
        if (rise) begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_ONE;
            if (bit_q >= CMD_BITS) begin
                rx_d = {rx_q[5:0], f_miso};
                if (bit_q[2:0] == 3'd7) begin
                    load_d = 1'b1;
                    addr_d = byte_q;
                    data_d = {rx_q, f_miso};
                    byte_d = byte_q + BYTE_ONE;
                end
            end
            if (bit_q == LAST_BIT) begin
                state_d = ST_TAIL;
            end
        end
    end

    assign f_sclk = sclk_q;
    assign f_cs   = cs_q;
    assign f_mosi = mosi_q;
    assign load   = load_q;
    assign addr   = addr_q;
    assign data   = data_q;
    assign f_done = done_q;

endmodule

// File: tb/tb_flash_loader.sv
// Directed bench for flash_loader: two instances (8-byte/CLK_DIV=2 and 1-byte/CLK_DIV=1)
// each served by a behavioural SPI flash model.
module tb_flash_loader;

    logic            clk = 1'b0;
    logic [1:0]      rst = 2'b11;
    logic [1:0]      sclk, cs, mosi, load, done;
    logic [1:0]      miso = 2'b00;
    logic [1:0][7:0] addr, data;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [2][8];
    int         nb [2];
    int         cd [2];

    int          cyc = 0;
    int          rises [2], ldn [2], bad [2], run [2], viol [2], bitn [2];
    int          last_load_cyc [2], cs_rise_cyc [2];
    logic [31:0] cmd_rx [2];
    logic [7:0]  ld_addr [2][8];
    logic [7:0]  ld_data [2][8];
    logic        prev_sclk [2], prev_cs [2], prev_done [2];
    logic        sclk_at_fall [2], sclk_at_rise [2], done_at_rise [2], done_before [2];

    always #5 clk = ~clk;

    flash_loader #(
        .FLASH_ADDR  (24'h100000),
        .NUM_BYTES   (8),
        .ADDR_W      (8),
        .CLK_DIV     (2),
        .STARTUP_WAIT(10)
    ) dut0 (
        .clk   (clk),
        .rst   (rst[0]),
        .f_sclk(sclk[0]),
        .f_cs  (cs[0]),
        .f_mosi(mosi[0]),
        .f_miso(miso[0]),
        .load  (load[0]),
        .addr  (addr[0]),
        .data  (data[0]),
        .f_done(done[0])
    );

    flash_loader #(
        .FLASH_ADDR  (24'h100000),
        .NUM_BYTES   (1),
        .ADDR_W      (8),
        .CLK_DIV     (1),
        .STARTUP_WAIT(16)
    ) dut1 (
        .clk   (clk),
        .rst   (rst[1]),
        .f_sclk(sclk[1]),
        .f_cs  (cs[1]),
        .f_mosi(mosi[1]),
        .f_miso(miso[1]),
        .load  (load[1]),
        .addr  (addr[1]),
        .data  (data[1]),
        .f_done(done[1])
    );

    // Flash model plus bus monitor, both observed on the inactive clock edge.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                rises[d] = 0; ldn[d] = 0; bad[d] = 0; run[d] = 0; viol[d] = 0; bitn[d] = 0;
                last_load_cyc[d] = 0; cs_rise_cyc[d] = 0; cmd_rx[d] = '0;
                prev_sclk[d] = 1'b0; prev_cs[d] = 1'b1; prev_done[d] = 1'b0;
                sclk_at_fall[d] = 1'bx; sclk_at_rise[d] = 1'bx;
                done_at_rise[d] = 1'bx; done_before[d] = 1'bx;
                miso[d] = 1'b0;
            end else begin
                if (!cs[d] && prev_cs[d]) begin
                    sclk_at_fall[d] = sclk[d];
                    bitn[d] = 0;
                    cmd_rx[d] = '0;
                end
                if (cs[d] && !prev_cs[d]) begin
                    sclk_at_rise[d] = sclk[d];
                    done_at_rise[d] = done[d];
                    done_before[d] = prev_done[d];
                    cs_rise_cyc[d] = cyc;
                end
                if (!cs[d]) begin
                    if (sclk[d] && !prev_sclk[d]) begin
                        rises[d]++;
                        if (bitn[d] < 32) cmd_rx[d] = {cmd_rx[d][30:0], mosi[d]};
                        bitn[d]++;
                    end
                    if (!sclk[d] && prev_sclk[d] && bitn[d] >= 32) begin
                        int j;
                        j = bitn[d] - 32;
                        if (j < 8 * nb[d]) miso[d] = mem[d][j / 8][7 - (j % 8)];
                    end
                    if (prev_cs[d] || sclk[d] != prev_sclk[d]) begin
                        if (!prev_cs[d] && run[d] != cd[d]) bad[d]++;
                        run[d] = 1;
                    end else begin
                        run[d]++;
                    end
                end else if (!prev_cs[d] && run[d] != cd[d]) begin
                    bad[d]++;
                end
                if (load[d]) begin
                    if (ldn[d] < 8) begin
                        ld_addr[d][ldn[d]] = addr[d];
                        ld_data[d][ldn[d]] = data[d];
                    end
                    ldn[d]++;
                    last_load_cyc[d] = cyc;
                end
                if (prev_done[d] && (sclk[d] || !cs[d] || load[d] || !done[d])) viol[d]++;
                prev_sclk[d] = sclk[d];
                prev_cs[d] = cs[d];
                prev_done[d] = done[d];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int d, input int limit);
        for (int i = 0; i < limit && done[d] !== 1'b1; i++) cycles(1);
        chk("done_reached", 32'(done[d]), 32'd1);
        cycles(2);
    endtask

    task automatic check_loads(input int d, input string tag);
        chk({tag, "_load_count"}, ldn[d], nb[d]);
        for (int i = 0; i < nb[d]; i++) begin
            chk({tag, "_addr"}, 32'(ld_addr[d][i]), i);
            chk({tag, "_data"}, 32'(ld_data[d][i]), 32'(mem[d][i]));
        end
    endtask

    initial begin
        mem[0][0] = 8'hA5; mem[0][1] = 8'h5A; mem[0][2] = 8'h00; mem[0][3] = 8'hFF;
        mem[0][4] = 8'h12; mem[0][5] = 8'h34; mem[0][6] = 8'h80; mem[0][7] = 8'h01;
        for (int i = 0; i < 8; i++) mem[1][i] = 8'h00;
        mem[1][0] = 8'hC3;
        nb[0] = 8; nb[1] = 1;
        cd[0] = 2; cd[1] = 1;

        // Reset values
        cycles(3);
        chk("rst_cs",   32'(cs[0]),   32'd1);
        chk("rst_sclk", 32'(sclk[0]), 32'd0);
        chk("rst_mosi", 32'(mosi[0]), 32'd0);
        chk("rst_load", 32'(load[0]), 32'd0);
        chk("rst_addr", 32'(addr[0]), 32'd0);
        chk("rst_data", 32'(data[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);

        // Startup timing: cs falls on the 10th edge after release, sclk rises 2 later
        rst[0] = 1'b0;
        cycles(9);
        chk("cs_before_wait", 32'(cs[0]), 32'd1);
        cycles(1);
        chk("cs_after_wait", 32'(cs[0]), 32'd0);
        chk("mosi_first_bit", 32'(mosi[0]), 32'd0);
        cycles(1);
        chk("sclk_setup_low", 32'(sclk[0]), 32'd0);
        cycles(1);
        chk("sclk_first_rise", 32'(sclk[0]), 32'd1);

        // Full 8-byte transfer
        wait_done(0, 2000);
        chk("cmd_decode", cmd_rx[0], 32'h03100000);
        check_loads(0, "run1");
        chk("rise_count", rises[0], 32'd96);
        chk("sclk_period", bad[0], 32'd0);
        chk("sclk_at_cs_fall", 32'(sclk_at_fall[0]), 32'd0);
        chk("sclk_at_cs_rise", 32'(sclk_at_rise[0]), 32'd0);
        chk("done_with_cs_rise", 32'(done_at_rise[0]), 32'd1);
        chk("done_before_cs_rise", 32'(done_before[0]), 32'd0);
        chk("last_load_before_cs", 32'(last_load_cyc[0] < cs_rise_cyc[0]), 32'd1);
        chk("addr_hold", 32'(addr[0]), 32'd7);
        chk("data_hold", 32'(data[0]), 32'h01);

        // Terminal state stays quiet
        cycles(1000);
        chk("done_quiet", viol[0], 32'd0);
        chk("done_sticky", 32'(done[0]), 32'd1);
        chk("no_extra_loads", ldn[0], 32'd8);

        // Reset mid-transfer after the 3rd load, then full restart
        rst[0] = 1'b1;
        cycles(2);
        rst[0] = 1'b0;
        for (int i = 0; i < 2000 && ldn[0] < 3; i++) cycles(1);
        chk("mid_load_count", ldn[0], 32'd3);
        rst[0] = 1'b1;
        #1;
        chk("mid_rst_cs",   32'(cs[0]),   32'd1);
        chk("mid_rst_sclk", 32'(sclk[0]), 32'd0);
        chk("mid_rst_load", 32'(load[0]), 32'd0);
        chk("mid_rst_done", 32'(done[0]), 32'd0);
        cycles(3);
        rst[0] = 1'b0;
        wait_done(0, 2000);
        check_loads(0, "run2");
        chk("run2_cmd", cmd_rx[0], 32'h03100000);
        chk("run2_rises", rises[0], 32'd96);

        // Single byte, CLK_DIV=1
        rst[1] = 1'b0;
        wait_done(1, 500);
        check_loads(1, "nb1");
        chk("nb1_cmd", cmd_rx[1], 32'h03100000);
        chk("nb1_rises", rises[1], 32'd40);
        chk("nb1_period", bad[1], 32'd0);
        chk("nb1_sclk_at_cs_rise", 32'(sclk_at_rise[1]), 32'd0);
        chk("nb1_done_with_cs_rise", 32'(done_at_rise[1]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
